// File: rtl/sha256_nonce_feeder.sv
// sha256_nonce_feeder: drives an external sha256_transform to run double
// SHA-256 over every nonce of a mining job and reports digests that hit.
//
// Optional build macro FULL_TARGET_EN: adds i_target[255:0] and replaces the
// "H2 word 7 == 0" hit rule with a full little-endian compare against target.
//
// Job handshake (valid/ready): a job transfers on a rising edge where
// i_job_valid && o_job_ready. o_job_ready is high only in IDLE, so any offer
// made while busy is dropped, never queued.
//
// Data words: the transform byte-swaps each tr_data word internally, so every
// word is driven byte-reversed. The nonce is the header's little-endian field,
// so its big-endian word value is the byte-reversed nonce; after the feeder's
// own swap the nonce therefore appears unswapped on tr_data word 3.
module sha256_nonce_feeder #(
  parameter int NONCE_STEP     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_job_valid,
  output logic         o_job_ready,
  input  logic [255:0] i_midstate,
  input  logic [95:0]  i_tail,
  input  logic [31:0]  i_nonce_start,
  input  logic [31:0]  i_nonce_end,
`ifdef FULL_TARGET_EN
  input  logic [255:0] i_target,
`endif
  output logic         o_tr_reset,
  output logic [511:0] o_tr_data,
  output logic [255:0] o_tr_state,
  input  logic [255:0] i_tr_out,
  input  logic         i_tr_finished,
  output logic         o_found_valid,
  output logic [31:0]  o_found_nonce,
  output logic [255:0] o_found_hash,
  output logic         o_done,
  output logic         o_busy,
  output logic         o_timeout_err,
  output logic [2:0]   o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_RUN1  = 3'd2,
    S_LOAD2 = 3'd3,
    S_RUN2  = 3'd4,
    S_CHECK = 3'd5,
    S_ABORT = 3'd6
  } state_t;

  // Watchdog counts RUN cycles 0..TIMEOUT_CYCLES-1; the last value aborts.
  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [255:0] SHA_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic [255:0]    r_midstate;
  logic [95:0]     r_tail;
  logic [31:0]     r_nonce;
  logic [31:0]     r_nonce_end;
  logic [255:0]    r_h1;
  logic [255:0]    r_h2;
  logic [WD_W-1:0] r_wdog;
  logic            r_found_valid;
  logic [31:0]     r_found_nonce;
  logic [255:0]    r_found_hash;
  logic            r_done;
  logic            r_timeout_err;

  logic [511:0]    w_blk1;
  logic [511:0]    w_blk2;
  logic [255:0]    w_ff;
  logic            w_hit;
  logic            w_wd_expired;

  assign w_wd_expired = (r_wdog == WD_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_job_valid) w_next = S_LOAD1;
      S_LOAD1: w_next = S_RUN1;
      S_RUN1: begin
        if (i_tr_finished)     w_next = S_LOAD2;
        else if (w_wd_expired) w_next = S_ABORT;
      end
      S_LOAD2: w_next = S_RUN2;
      S_RUN2: begin
        if (i_tr_finished)     w_next = S_CHECK;
        else if (w_wd_expired) w_next = S_ABORT;
      end
      S_CHECK: w_next = (r_nonce == r_nonce_end) ? S_IDLE : S_LOAD1;
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Padded message blocks for both passes, each word byte-reversed for the transform.
  always_comb begin
    w_blk1 = '0;
    w_blk2 = '0;
    for (int k = 0; k < 3; k++) w_blk1[32*k +: 32] = bswap32(r_tail[32*k +: 32]);
    w_blk1[127:96]  = r_nonce;
    w_blk1[159:128] = bswap32(32'h80000000);
    w_blk1[511:480] = bswap32(32'h00000280);
    for (int k = 0; k < 8; k++) w_blk2[32*k +: 32] = bswap32(r_h1[32*k +: 32]);
    w_blk2[287:256] = bswap32(32'h80000000);
    w_blk2[511:480] = bswap32(32'h00000100);
  end

  // Transform inputs follow the pass in progress; held stable through RUN.
  always_comb begin
    o_tr_data  = w_blk1;
    o_tr_state = r_midstate;
    if (r_state == S_LOAD2 || r_state == S_RUN2) begin
      o_tr_data  = w_blk2;
      o_tr_state = SHA_IV;
    end
  end

  // Feed-forward: per-word sum of the chaining state and the working variables.
  always_comb begin
    w_ff = '0;
    for (int k = 0; k < 8; k++) w_ff[32*k +: 32] = o_tr_state[32*k +: 32] + i_tr_out[32*k +: 32];
  end

`ifdef FULL_TARGET_EN
  logic [255:0] r_target;
  logic [255:0] w_h2_le;

  // Target is part of the job and is latched with it.
  always_ff @(posedge i_clk) begin
    if (!i_reset)                            r_target <= '0;
    else if (r_state == S_IDLE && i_job_valid) r_target <= i_target;
  end

  // Digest bytes read as a little-endian 256-bit integer.
  always_comb begin
    w_h2_le = '0;
    for (int k = 0; k < 32; k++) w_h2_le[8*k +: 8] = r_h2[32*(k/4) + 24 - 8*(k%4) +: 8];
  end

  assign w_hit = (w_h2_le <= r_target);
`else
  assign w_hit = (r_h2[255:224] == 32'd0);
`endif

  // Job registers, pass results, watchdog and host-side reporting.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_midstate    <= '0;
      r_tail        <= '0;
      r_nonce       <= '0;
      r_nonce_end   <= '0;
      r_h1          <= '0;
      r_h2          <= '0;
      r_wdog        <= '0;
      r_found_valid <= 1'b0;
      r_found_nonce <= '0;
      r_found_hash  <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_found_valid <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_job_valid) begin
            r_midstate    <= i_midstate;
            r_tail        <= i_tail;
            r_nonce       <= i_nonce_start;
            r_nonce_end   <= i_nonce_end;
            r_timeout_err <= 1'b0;
          end
        end
        S_LOAD1, S_LOAD2: r_wdog <= '0;
        S_RUN1: begin
          if (i_tr_finished) r_h1 <= w_ff;
          else               r_wdog <= r_wdog + WD_W'(1);
        end
        S_RUN2: begin
          if (i_tr_finished) r_h2 <= w_ff;
          else               r_wdog <= r_wdog + WD_W'(1);
        end
        S_CHECK: begin
          if (w_hit) begin
            r_found_valid <= 1'b1;
            r_found_nonce <= r_nonce;
            r_found_hash  <= r_h2;
          end
          if (r_nonce == r_nonce_end) r_done <= 1'b1;
          else                        r_nonce <= r_nonce + 32'(NONCE_STEP);
        end
        S_ABORT: begin
          r_timeout_err <= 1'b1;
          r_done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The transform is held in restart in IDLE and strobed for one cycle per pass.
  assign o_tr_reset    = !(r_state == S_IDLE || r_state == S_LOAD1 || r_state == S_LOAD2);
  assign o_job_ready   = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_found_valid = r_found_valid;
  assign o_found_nonce = r_found_nonce;
  assign o_found_hash  = r_found_hash;
  assign o_done        = r_done;
  assign o_timeout_err = r_timeout_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sha256_nonce_feeder.sv
// tb_sha256_nonce_feeder: directed bench with a behavioural SHA-256 transform.
module tb_sha256_nonce_feeder;

  localparam int LAT = 4;                  // transform RUN cycles incl. the finished cycle
  localparam int PER = 2 * (1 + LAT) + 1;  // cycles per nonce
  localparam logic [255:0] GEN_DISP =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [31:0] ns;
    logic [31:0] ne;
    int          n_nonces;
    int          n_hits;
    logic        last_hit;
  } vec_t;

  logic         clk, rst_n, job_valid, job_ready;
  logic [255:0] midstate;
  logic [95:0]  tail;
  logic [31:0]  nonce_start, nonce_end;
  logic         tr_reset, tr_finished;
  logic [511:0] tr_data;
  logic [255:0] tr_state, tr_out;
  logic         found_valid, done, busy, timeout_err;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [2:0]   dbg_state;
`ifdef FULL_TARGET_EN
  logic [255:0] target;
`endif

  logic [255:0] job_mid;
  logic [95:0]  job_tail;
  logic [31:0]  tm_cnt;
  logic         tm_en;
  int           total, bad;
  vec_t         vecs[4];

  sha256_nonce_feeder #(.NONCE_STEP(1), .TIMEOUT_CYCLES(255)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_job_valid(job_valid), .o_job_ready(job_ready),
    .i_midstate(midstate), .i_tail(tail), .i_nonce_start(nonce_start), .i_nonce_end(nonce_end),
`ifdef FULL_TARGET_EN
    .i_target(target),
`endif
    .o_tr_reset(tr_reset), .o_tr_data(tr_data), .o_tr_state(tr_state),
    .i_tr_out(tr_out), .i_tr_finished(tr_finished),
    .o_found_valid(found_valid), .o_found_nonce(found_nonce), .o_found_hash(found_hash),
    .o_done(done), .o_busy(busy), .o_timeout_err(timeout_err), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference SHA-256 ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [511:0] swap_blk(input logic [511:0] x);
    logic [511:0] r;
    for (int t = 0; t < 16; t++) r[32*t +: 32] = bsw(x[32*t +: 32]);
    return r;
  endfunction

  // 64 rounds; returns working variables a..h (a in the low word), no feed-forward.
  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] w_in);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = w_in[32*t +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {h, g, f, e, d, c, b, a} = st;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h, g, f, e, d, c, b, a};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = x[32*k +: 32] + y[32*k +: 32];
    return r;
  endfunction

  // Big-endian word values of the two header/digest blocks.
  function automatic logic [511:0] blk1_w(input logic [95:0] tl, input logic [31:0] n);
    logic [511:0] r;
    r = '0;
    r[95:0]    = tl;
    r[127:96]  = bsw(n);
    r[159:128] = 32'h80000000;
    r[511:480] = 32'h00000280;
    return r;
  endfunction

  function automatic logic [511:0] blk2_w(input logic [255:0] h1);
    logic [511:0] r;
    r = '0;
    r[255:0]   = h1;
    r[287:256] = 32'h80000000;
    r[511:480] = 32'h00000100;
    return r;
  endfunction

  // Displayed hash: digest bytes reversed, read as one 256-bit number.
  function automatic logic [255:0] disp(input logic [255:0] h);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = h[32*(k/4) + 24 - 8*(k%4) +: 8];
    return r;
  endfunction

  // ---------------- transform model ----------------
  always @(posedge clk) begin
    if (!tr_reset) tm_cnt <= '0;
    else           tm_cnt <= tm_cnt + 32'd1;
  end
  assign tr_finished = tm_en && tr_reset && (tm_cnt == 32'(LAT - 1));
  always_comb tr_out = compress(tr_state, swap_blk(tr_data));

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- job driver + scoreboard ----------------
  task automatic run_job(input logic [31:0] ns, input logic [31:0] ne, input int n_nonces,
                         input int n_hits, input logic last_hit, input bit spam);
    logic [31:0]  exp_q[$];
    logic [31:0]  nn, cur;
    logic [255:0] h1, h2;
    int           cyc, starts, hits;
    bit           fin;
    nn = ns;
    for (int i = 0; i < n_nonces; i++) begin
      exp_q.push_back(nn);
      nn = nn + 32'd1;
    end
    cur = '0; h1 = '0; h2 = '0;
    @(negedge clk);
    chk("ready_idle", 512'(job_ready), 512'(1'b1));
    job_valid = 1'b1; midstate = job_mid; tail = job_tail; nonce_start = ns; nonce_end = ne;
    @(negedge clk);
    job_valid = 1'b0;
    cyc = 1; starts = 0; hits = 0; fin = 0;
    while (!fin && cyc < n_nonces * PER + 50) begin
      if (cyc == 1) chk("terr_clear_on_accept", 512'(timeout_err), 512'(1'b0));
      if (spam) begin
        job_valid = (cyc >= 2 && cyc < 8);
        midstate = ~job_mid; nonce_start = 32'h55; nonce_end = 32'h55;
        if (cyc < 8) chk("ready_while_busy", 512'(job_ready), 512'(1'b0));
      end
      if (found_valid) begin
        hits++;
        chk("found_nonce", 512'(found_nonce), 512'(cur));
        chk("found_hash", 512'(found_hash), 512'(h2));
`ifdef FULL_TARGET_EN
        chk("hit_rule", 512'(disp(h2) <= target), 512'(1'b1));
`else
        chk("hit_rule", 512'(h2[255:224]), 512'(32'd0));
`endif
      end
      if (busy && !tr_reset && tr_state == job_mid) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else                  chk("extra_block1", 512'(tr_data[127:96]), 512'(32'hx));
        starts++;
        chk("blk1_nonce", 512'(tr_data[127:96]), 512'(cur));
        chk("blk1_data", tr_data, swap_blk(blk1_w(job_tail, cur)));
        h1 = add8(job_mid, compress(job_mid, blk1_w(job_tail, cur)));
        h2 = add8(IV, compress(IV, blk2_w(h1)));
      end
      if (busy && !tr_reset && tr_state == IV)
        chk("blk2_data", tr_data, swap_blk(blk2_w(h1)));
      if (done) begin
        fin = 1;
        chk("done_cycle", 512'(cyc), 512'(n_nonces * PER + 1));
        chk("busy_at_done", 512'(busy), 512'(1'b0));
        chk("found_with_done", 512'(found_valid), 512'(last_hit));
        chk("block1_starts", 512'(starts), 512'(n_nonces));
        chk("hit_count", 512'(hits), 512'(n_hits));
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", 512'(fin), 512'(1'b1));
    job_valid = 1'b0;
    midstate = job_mid;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [511:0] blk0;
    int cyc;
    bit seen;
    total = 0; bad = 0;
    rst_n = 1'b0; job_valid = 1'b0; tm_en = 1'b1;
    nonce_start = '0; nonce_end = '0;
    blk0 = '0;
    blk0[31:0]    = 32'h01000000;
    blk0[32*9 +: 32]  = 32'h3ba3edfd; blk0[32*10 +: 32] = 32'h7a7b12b2;
    blk0[32*11 +: 32] = 32'h7ac72c3e; blk0[32*12 +: 32] = 32'h67768f61;
    blk0[32*13 +: 32] = 32'h7fc81bc3; blk0[32*14 +: 32] = 32'h888a5132;
    blk0[32*15 +: 32] = 32'h3a9fb8aa;
    job_mid  = add8(IV, compress(IV, blk0));
    job_tail = {32'hffff001d, 32'h29ab5f49, 32'h4b1e5e4a};
    midstate = job_mid; tail = job_tail;
`ifdef FULL_TARGET_EN
    target = GEN_DISP;
`endif
    vecs[0] = '{32'h7C2BAC1D, 32'h7C2BAC1D, 1, 1, 1'b1};
    vecs[1] = '{32'h7C2BAC1B, 32'h7C2BAC1F, 5, 1, 1'b0};
    vecs[2] = '{32'hFFFFFFFE, 32'h00000001, 4, 0, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000005, 1, 0, 1'b0};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tr_reset", 512'(tr_reset), 512'(1'b0));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    chk("rst_ready", 512'(job_ready), 512'(1'b1));
    chk("rst_found_valid", 512'(found_valid), 512'(1'b0));
    chk("rst_done", 512'(done), 512'(1'b0));
    chk("rst_terr", 512'(timeout_err), 512'(1'b0));
    chk("rst_found_hash", 512'(found_hash), 512'(0));
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++)
      run_job(vecs[v].ns, vecs[v].ne, vecs[v].n_nonces, vecs[v].n_hits, vecs[v].last_hit, 1'b0);
    // the genesis hit stays held across jobs without hits
    chk("genesis_nonce", 512'(found_nonce), 512'(32'h7C2BAC1D));
    chk("genesis_disp", 512'(disp(found_hash)), 512'(GEN_DISP));

    // watchdog abort in RUN1
    tm_en = 1'b0;
    @(negedge clk);
    job_valid = 1'b1; nonce_start = 32'h10; nonce_end = 32'h10;
    @(negedge clk);
    job_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_done_cycle", 512'(cyc), 512'(258));
    chk("abort_terr", 512'(timeout_err), 512'(1'b1));
    chk("abort_no_found", 512'(found_valid), 512'(1'b0));
    chk("abort_busy", 512'(busy), 512'(1'b0));
    repeat (3) @(negedge clk);
    chk("terr_sticky", 512'(timeout_err), 512'(1'b1));
    tm_en = 1'b1;

    // offers while busy are ignored; latched job inputs are used throughout
    run_job(32'h00000020, 32'h00000020, 1, 0, 1'b0, 1'b1);

`ifdef FULL_TARGET_EN
    target = GEN_DISP - 256'd1;
    run_job(32'h7C2BAC1D, 32'h7C2BAC1D, 1, 0, 1'b0, 1'b0);
    target = GEN_DISP;
`endif

    // reset during RUN2 discards the job
    @(negedge clk);
    job_valid = 1'b1; nonce_start = 32'h7C2BAC1D; nonce_end = 32'h7C2BAC1D;
    @(negedge clk);
    job_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy && tr_reset && tr_state == IV) seen = 1;
      else @(negedge clk);
    end
    chk("reach_run2", 512'(seen), 512'(1'b1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 512'(busy), 512'(1'b0));
    chk("midrst_ready", 512'(job_ready), 512'(1'b1));
    chk("midrst_tr_reset", 512'(tr_reset), 512'(1'b0));
    chk("midrst_found_nonce", 512'(found_nonce), 512'(0));
    chk("midrst_found_hash", 512'(found_hash), 512'(0));
    chk("midrst_done", 512'(done), 512'(1'b0));
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("midrst_job_gone", 512'(seen), 512'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_nonce_feeder.md
Name: sha256_nonce_feeder

Overview:
- Initiator-side driver for sha256_transform. Takes a mining job (midstate, 12-byte header tail, nonce range) and runs double SHA-256 for each nonce.
- For each nonce: builds the padded second header block, restarts the transform, applies the feed-forward add to the result, then builds and hashes the 256-bit digest block.
- Checks each final hash and reports hits to the host-side job interface.

Parameters:
NONCE_STEP, 1, increment applied to nonce between attempts (mod 2^32)
TIMEOUT_CYCLES, 255, max cycles to wait for tr_finished per transform pass before aborting the job

Ports:
clk  in  1  system clock
reset  in  1  reset; one clock; reset is synchronous and active-low
job_valid  in  1  job offer; accepted when job_valid && job_ready
job_ready  out  1  high only in IDLE
midstate  in  256  chaining state after header block 1; word i at [32i+31:32i], word 0 = a
tail  in  96  header bytes 64..75 as 3 words, same word order as midstate
nonce_start  in  32  first nonce
nonce_end  in  32  last nonce, inclusive
tr_reset  out  1  active-low restart strobe to the transform
tr_data  out  512  message block to the transform; word 0 at [31:0]
tr_state  out  256  chaining state to the transform
tr_out  in  256  transform working-variable result (a..h)
tr_finished  in  1  transform result valid
found_valid  out  1  one-cycle pulse: hit
found_nonce  out  32  nonce of the hit; held until the next hit
found_hash  out  256  final digest of the hit; held until the next hit
done  out  1  one-cycle pulse: range exhausted or aborted
busy  out  1  high outside IDLE
timeout_err  out  1  sticky; set on watchdog abort, cleared on job accept or reset

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, tr_reset=0.
  - found_valid, done, busy, timeout_err = 0; found_nonce, found_hash = 0.
  - Reset mid-job discards the job.
- Word packing:
  - The transform byte-swaps each data word internally, so the feeder presents every data word byte-reversed.
  - Numeric values below are the pre-swap (big-endian) values.
- Block 1 (first hash):
  - words 0..2 = tail; word 3 = nonce; word 4 = 0x80000000; words 5..14 = 0; word 15 = 0x00000280.
  - tr_state = midstate.
- Block 2 (second hash):
  - words 0..7 = H1; word 8 = 0x80000000; words 9..14 = 0; word 15 = 0x00000100.
  - tr_state = SHA-256 IV (0x6a09e667 .. 0x5be0cd19).
- Feed-forward: Hn[i] = tr_state[i] + tr_out[i] mod 2^32, per word, computed by the feeder.
- FSM states:
  - IDLE: job_ready=1. On job accept, latch all job inputs, nonce=nonce_start, clear timeout_err, go to LOAD1.
  - LOAD1: drive block 1; tr_reset=0 for exactly 1 cycle; go to RUN1. Watchdog counter cleared.
  - RUN1: tr_reset=1, tr_data/tr_state held stable. On tr_finished, register H1 and go to LOAD2. Watchdog expiry goes to ABORT.
  - LOAD2 / RUN2: same as LOAD1 / RUN1 with block 2; on tr_finished, register H2 and go to CHECK.
  - CHECK (1 cycle): evaluate hit. On hit, pulse found_valid and update found_nonce / found_hash. If nonce==nonce_end, pulse done and go to IDLE; else nonce += NONCE_STEP and go to LOAD1.
  - ABORT: set timeout_err, pulse done, go to IDLE.
- Hit rule (default): H2 word 7 == 0.
- Timing:
  - tr_finished is sampled only in RUN1/RUN2 and ignored in all other states.
  - Latency per nonce = 2 × (1 + transform latency) + 1 cycles.
- Boundaries:
  - nonce_start==nonce_end: exactly one nonce.
  - nonce_end < nonce_start: range wraps through 0xFFFFFFFF to 0.
  - If NONCE_STEP skips past nonce_end, iteration continues until nonce equals nonce_end. The host must pick a compatible range.
  - Hit on the last nonce: found_valid and done pulse in the same cycle.
  - job_valid while busy: ignored, no queueing.

Optional Feature:
FULL_TARGET_EN:
- Adds input port target[255:0], a little-endian 256-bit integer.
- The hit rule becomes: H2 interpreted as a little-endian 256-bit integer (byte-reversed digest) <= target.
- Without the macro: no target port; hit rule is word 7 == 0.

Test Plan:
- Genesis header (midstate and tail from block 0), nonce_start=nonce_end=0x7C2BAC1D, transform model -> one found_valid, found_nonce=0x7C2BAC1D, displayed hash 000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f, done in the same cycle.
- Same job with range 0x7C2BAC1B..0x7C2BAC1F -> exactly 5 block-1 starts, one hit, done after the 5th CHECK, busy low the next cycle.
- Range 0xFFFFFFFE..0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 seen in block 1 word 3, then done.
- Transform model never asserts tr_finished -> ABORT after 255 cycles in RUN1, timeout_err=1, done pulse. A new job accept clears timeout_err.
- reset driven low during RUN2 -> next cycle: IDLE, all outputs at reset values. job_valid offered while busy -> not accepted.
- FULL_TARGET_EN build with genesis job: target = H2 -> hit; target = H2 - 1 -> no found_valid, done only.
